uart_tx_fifo: RTL

- Byte buffer and transmit sequencer that sits directly upstream of the UART transmitter.
- Producers (ALU result path, command interface) push bytes at any rate up to one per clock.
- The block hands the bytes one at a time to the transmitter and waits for its completion pulse before issuing the next.
- Decouples producer bursts from serial line speed; reports full/empty/overflow status.

---
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_tx_fifo.sv | 88 ++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Bundle of producer-side, transmitter-side and status signals for uart_tx_fifo.
// Handshakes: a write is taken on every edge with i_wr=1 and o_full=0. o_tx_start pulses for one cycle per byte. The next byte follows only after i_tx_done.
interface uart_tx_fifo_if #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
);
  logic               i_wr;
  logic [NB_DATA-1:0] i_wdata;
  logic               i_clr_ovf;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_full;
  logic               o_empty;
  logic [NB_ADDR:0]   o_count;
  logic               o_overflow;
  logic               o_busy;
  logic               o_dbg_state;

  modport slave (
    input  i_wr, i_wdata, i_clr_ovf, i_tx_done,
    output o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow, o_busy,
    output o_dbg_state
  );

  modport master (
    output i_wr, i_wdata, i_clr_ovf, i_tx_done,
    input  o_tx_start, o_tx_data, o_full, o_empty, o_count, o_overflow, o_busy,
    input  o_dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter one byte at a time. Each byte is issued with a start pulse.
// The next byte is issued only after the transmitter returns its done pulse.
module uart_tx_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  uart_tx_fifo_if.slave  bus
);
  localparam int DEPTH = 2**NB_ADDR;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr, rd_ptr;
  logic [NB_ADDR:0]   count;
  logic               tx_start, tx_start_nxt;
  logic [NB_DATA-1:0] tx_data;
  logic               overflow;
  logic               full, empty, wr_ok, pop;

  // Status comes from the occupancy counter because equal pointers mean either full or empty.
  assign full  = (count == (NB_ADDR+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = bus.i_wr && !full;

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    tx_start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          tx_start_nxt = 1'b1;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        // A done pulse that lines up with our own start pulse belongs to an earlier transfer.
        if (bus.i_tx_done && !tx_start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      tx_start <= tx_start_nxt;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      if (wr_ok && !pop)      count <= count + 1'b1;
      else if (!wr_ok && pop) count <= count - 1'b1;
      if (bus.i_wr && full)   overflow <= 1'b1;
      else if (bus.i_clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.i_wdata;
  end

  assign bus.o_tx_start  = tx_start;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count;
  assign bus.o_overflow  = overflow;
  assign bus.o_busy      = (state == WAIT);
  assign bus.o_dbg_state = state;
endmodule
